alu_operand_seq: RTL and testbench
==================================

# alu_operand_seq

Multi-cycle operand sequencer and result/flag register wrapped around the 8-bit 74181-style ALU. It accepts an operation code, takes operands A and B from a shared 8-bit data bus over two handshaked transfers, and presents them with S/M/CN to the combinational ALU. It then captures F, CO and FZ into a result register and a flag register. The carry flag can feed back as CN to support multi-byte arithmetic chains.

## Interface
- Parameters: none (data width fixed at 8).
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a new operation; sampled only in IDLE.
- OP  in  5  {M, S[3:0]}; latched on accepted START.
- USE_CY  in  1  1: CN driven from carry flag; 0: CN = CIN. Latched on accepted START.
- CIN  in  1  external carry-in; latched on accepted START.
- DIN  in  8  operand bus.
- DIN_VLD  in  1  DIN holds a valid operand this cycle.
- DIN_RDY  out  1  sequencer will take DIN this cycle.
- A, B  out  8  operand registers to ALU.
- S  out  4, M  out  1, CN  out  1  ALU control, from latched op.
- F  in  8, CO  in  1, FZ  in  1  ALU results; FZ=0 means A==B.
- DOUT  out  8  result register.
- CY  out  1  carry flag.
- ZF  out  1  1 when captured result == 0.
- EQ  out  1  1 when A==B at capture (inverted FZ).
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse, result and flags valid.

## Operation
- States: IDLE, LD_A, LD_B, EXEC, FIN.
- IDLE: START=1 latches OP, USE_CY and CIN, then goes to LD_A. START is ignored in all other states.
- LD_A: DIN_RDY=1. DIN_VLD=1 loads A<=DIN and goes to LD_B. Otherwise the state holds and waits indefinitely.
- LD_B: DIN_RDY=1. DIN_VLD=1 loads B<=DIN and goes to EXEC.
- EXEC: A, B, S, M and CN are stable for the whole cycle. On the closing edge:
  - DOUT<=F, ZF<=(F==8'h00), EQ<=~FZ.
  - CY<=CO only if M==0. For M==1 (logic) operations CY is unchanged.
  - Next state is FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE. START in FIN is ignored.
- CN = USE_CY_latched ? CY : CIN_latched. It is combinational from registers, so the CY value in effect during EXEC is the one captured by the previous operation.
- DIN_RDY is 0 outside LD_A and LD_B. DIN_VLD is ignored there.
- DOUT, CY, ZF and EQ hold their values until the next EXEC capture.
- A and B hold their values after completion.
- Reset, including mid-operation: state goes to IDLE. A, B, DOUT, OP, CY, ZF, EQ, USE_CY and CIN all clear to 0, so S=0, M=0, CN=0. BUSY, DONE and DIN_RDY are 0. An in-flight operation is discarded with no DONE.

## Timing
- START accepted at edge t, with DIN_VLD held high:
  - LD_A during cycle t+1, LD_B during t+2, EXEC during t+3.
  - DONE is high during t+4.
  - Minimum START-to-DONE latency is 4 cycles.
- Each cycle DIN_VLD is low in LD_A or LD_B adds one cycle.
- A new START may be accepted in the first IDLE cycle after FIN. Back-to-back throughput is 5 cycles per operation.
- BUSY is high from t+1 through t+4 inclusive.
- The ALU path is fully combinational: A/B/S/M/CN registers to F/CO/FZ, then back into DOUT/CY/ZF/EQ within one cycle.

## Structure
- Shared package:
  - state encoding constants (IDLE=0 … FIN=4, 3 bits);
  - OP field positions (M=bit 4, S=bits 3:0);
  - named S codes used by software/bench: ADD=4'b1001, SUB=4'b0110, AND=4'b1011.
- No sub-module. The ALU is instantiated alongside this block at datapath level, not inside it. The bench instantiates both and wires A/B/S/M/CN and F/CO/FZ.

## Test plan
- Reset value check: assert RST for 2 cycles mid-LD_B -> state IDLE, all outputs 0, no DONE.
- ADD with overflow. OP={0,1001}, CIN=0, A=8'hFF, B=8'h01 -> DONE at t+4, DOUT=8'h00, CY=1, ZF=1, EQ=0.
- Chained ADD. Next op uses USE_CY=1 with A=8'h00, B=8'h00 -> CN=1, DOUT=8'h01, CY=0, ZF=0.
- SUB equal and SUB borrow:
  - OP={0,0110}, CIN=0, A=B=8'h05 -> DOUT=8'h00, CY=0, ZF=1, EQ=1.
  - A=8'h03, B=8'h05 -> DOUT=8'hFE, CY=1, EQ=0.
- Logic preserves carry. With CY=1, OP={1,1011}, A=8'hF0, B=8'h3C -> DOUT=8'h30, CY stays 1, ZF=0.
- Handshake stalls. DIN_VLD low for 3 cycles in LD_A and 2 in LD_B, with START pulsed while BUSY -> A/B loaded only on VLD cycles, DONE at t+9, extra START ignored.

Source files
------------

// File: rtl/alu_operand_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: state encoding, OP field
// layout and the S codes that software and verification refer to by name.
package alu_operand_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LD_A = 3'd1,
        ST_LD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam int OP_W     = 5;
    localparam int OP_M_BIT = 4;
    localparam int OP_S_MSB = 3;
    localparam int OP_S_LSB = 0;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;

    // Logic-mode operations leave the carry flag untouched.
    function automatic logic op_is_logic(input logic [OP_W-1:0] op);
        return op[OP_M_BIT];
    endfunction

endpackage

// File: rtl/alu_operand_seq.sv
// Operand sequencer around an external 8-bit 74181-style ALU: latches the op,
// collects A and B from a shared handshaked bus, then captures result and flags.
module alu_operand_seq
    import alu_operand_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [4:0] OP,
    input  logic       USE_CY,
    input  logic       CIN,
    input  logic [7:0] DIN,
    input  logic       DIN_VLD,
    output logic       DIN_RDY,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] S,
    output logic       M,
    output logic       CN,
    input  logic [7:0] F,
    input  logic       CO,
    input  logic       FZ,
    output logic [7:0] DOUT,
    output logic       CY,
    output logic       ZF,
    output logic       EQ,
    output logic       BUSY,
    output logic       DONE
);

    state_t       state_reg;
    logic [4:0]   op_reg;
    logic         use_cy_reg;
    logic         cin_reg;
    logic [7:0]   a_reg;
    logic [7:0]   b_reg;
    logic [7:0]   dout_reg;
    logic         cy_reg;
    logic         zf_reg;
    logic         eq_reg;
    logic         rdy_reg;
    logic         busy_reg;
    logic         done_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            use_cy_reg <= 1'b0;
            cin_reg    <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            dout_reg   <= '0;
            cy_reg     <= 1'b0;
            zf_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            rdy_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        op_reg     <= OP;
                        use_cy_reg <= USE_CY;
                        cin_reg    <= CIN;
                        state_reg  <= ST_LD_A;
                        rdy_reg    <= 1'b1;
                        busy_reg   <= 1'b1;
                    end
                end
                ST_LD_A: begin
                    if (DIN_VLD) begin
                        a_reg     <= DIN;
                        state_reg <= ST_LD_B;
                    end
                end
                ST_LD_B: begin
                    if (DIN_VLD) begin
                        b_reg     <= DIN;
                        state_reg <= ST_EXEC;
                        rdy_reg   <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    // ALU outputs settle combinationally during this cycle.
                    dout_reg <= F;
                    zf_reg   <= (F == 8'h00);
                    eq_reg   <= ~FZ;
                    if (!op_is_logic(op_reg)) begin
                        cy_reg <= CO;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= ST_FIN;
                end
                ST_FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    rdy_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign DIN_RDY = rdy_reg;
    assign A       = a_reg;
    assign B       = b_reg;
    assign S       = op_reg[OP_S_MSB:OP_S_LSB];
    assign M       = op_reg[OP_M_BIT];
    // Chained arithmetic sees the carry left by the previous operation.
    assign CN      = use_cy_reg ? cy_reg : cin_reg;
    assign DOUT    = dout_reg;
    assign CY      = cy_reg;
    assign ZF      = zf_reg;
    assign EQ      = eq_reg;
    assign BUSY    = busy_reg;
    assign DONE    = done_reg;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq with an ALU stand-in, a queue-based result model
// and randomized operations with random handshake stalls.
module tb_alu_operand_seq;
    import alu_operand_seq_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [4:0] OP = '0;
    logic       USE_CY = 1'b0;
    logic       CIN = 1'b0;
    logic [7:0] DIN = '0;
    logic       DIN_VLD = 1'b0;
    logic       DIN_RDY;
    logic [7:0] A, B, F, DOUT;
    logic [3:0] S;
    logic       M, CN, CO, FZ, CY, ZF, EQ, BUSY, DONE;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit model_cy = 1'b0;

    typedef struct {
        logic [7:0] a, b, dout;
        logic       cy, zf, eq;
        int         acc, lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_operand_seq dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .USE_CY(USE_CY), .CIN(CIN),
        .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .A(A), .B(B), .S(S), .M(M),
        .CN(CN), .F(F), .CO(CO), .FZ(FZ), .DOUT(DOUT), .CY(CY), .ZF(ZF), .EQ(EQ),
        .BUSY(BUSY), .DONE(DONE)
    );

    // 74181-style ALU stand-in, active-high data, CN=1 adds one / borrows one.
    always_comb begin
        logic [8:0] t;
        t  = '0;
        CO = 1'b0;
        F  = '0;
        if (!M) begin
            case (S)
                S_ADD:   t = {1'b0, A} + {1'b0, B} + {8'b0, CN};
                S_SUB:   t = {1'b0, A} - {1'b0, B} - {8'b0, CN};
                default: t = {1'b0, A} + {8'b0, CN};
            endcase
            F  = t[7:0];
            CO = t[8];
        end else begin
            case (S)
                4'b0000: F = ~A;
                4'b0001: F = ~(A | B);
                4'b0010: F = ~A & B;
                4'b0011: F = 8'h00;
                4'b0100: F = ~(A & B);
                4'b0101: F = ~B;
                4'b0110: F = A ^ B;
                4'b0111: F = A & ~B;
                4'b1000: F = ~A | B;
                4'b1001: F = ~(A ^ B);
                4'b1010: F = B;
                4'b1011: F = A & B;
                4'b1100: F = 8'hFF;
                4'b1101: F = A | ~B;
                4'b1110: F = A | B;
                default: F = A;
            endcase
        end
        FZ = (A != B);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: plain arithmetic on the operands and the running carry flag.
    function automatic exp_t model_op(input logic [4:0] op, input bit use_cy, input bit cin,
                                      input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   cn, r;
        cn = use_cy ? int'(model_cy) : int'(cin);
        e.a = a; e.b = b; e.cy = model_cy; e.acc = 0; e.lat = 0;
        if (op[4]) begin
            case (op[3:0])
                4'b1011: e.dout = a & b;
                4'b1110: e.dout = a | b;
                default: e.dout = a ^ b;
            endcase
        end else if (op[3:0] == S_ADD) begin
            r = int'(a) + int'(b) + cn;
            e.dout = 8'(r % 256);
            e.cy = (r > 255);
        end else begin
            r = int'(a) - int'(b) - cn;
            e.dout = 8'((r + 256) % 256);
            e.cy = (r < 0);
        end
        e.zf = (e.dout == 8'h00);
        e.eq = (a == b);
        return e;
    endfunction

    // Compare process: every DONE must match the oldest outstanding operation.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(DONE), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", 32'(DOUT), 32'(e.dout));
                chk("cy", 32'(CY), 32'(e.cy));
                chk("zf", 32'(ZF), 32'(e.zf));
                chk("eq", 32'(EQ), 32'(e.eq));
                chk("a_reg", 32'(A), 32'(e.a));
                chk("b_reg", 32'(B), 32'(e.b));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                $display("op a=%02h b=%02h dout=%02h cy=%0d zf=%0d eq=%0d lat=%0d",
                         A, B, DOUT, CY, ZF, EQ, cyc - e.acc);
            end
        end
    end

    // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle.
    task automatic run_op(input logic [4:0] op, input bit use_cy, input bit cin,
                          input logic [7:0] a, input logic [7:0] b,
                          input int stall_a, input int stall_b, input bit poke);
        exp_t e;
        int   n;
        e = model_op(op, use_cy, cin, a, b);
        START = 1'b1; OP = op; USE_CY = use_cy; CIN = cin;
        e.acc = cyc;
        e.lat = 4 + stall_a + stall_b;
        @(negedge CLK);
        START = 1'b0; OP = 5'($urandom); USE_CY = 1'($urandom); CIN = 1'($urandom);
        for (int i = 0; i < stall_a; i++) begin
            DIN_VLD = 1'b0; DIN = 8'($urandom); START = poke;
            chk("rdy_lda_stall", 32'(DIN_RDY), 32'd1);
            @(negedge CLK);
        end
        START = 1'b0; DIN_VLD = 1'b1; DIN = a;
        chk("rdy_lda", 32'(DIN_RDY), 32'd1);
        @(negedge CLK);
        for (int i = 0; i < stall_b; i++) begin
            DIN_VLD = 1'b0; DIN = 8'($urandom); START = poke;
            chk("rdy_ldb_stall", 32'(DIN_RDY), 32'd1);
            @(negedge CLK);
        end
        START = 1'b0; DIN_VLD = 1'b1; DIN = b;
        chk("rdy_ldb", 32'(DIN_RDY), 32'd1);
        if (!op[4]) model_cy = e.cy;
        exp_q.push_back(e);
        @(negedge CLK);
        DIN_VLD = 1'b0; DIN = 8'($urandom); START = poke;
        chk("rdy_exec", 32'(DIN_RDY), 32'd0);
        chk("busy_exec", 32'(BUSY), 32'd1);
        n = 0;
        while (!DONE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!DONE) chk("done_timeout", 32'(DONE), 32'd1);
        START = poke;
        @(negedge CLK);
        START = 1'b0;
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_done", 32'(DONE), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_rdy"}, 32'(DIN_RDY), 32'd0);
        chk({tag, "_ab"}, {16'd0, A, B}, 32'd0);
        chk({tag, "_dout"}, 32'(DOUT), 32'd0);
        chk({tag, "_flags"}, {29'd0, CY, ZF, EQ}, 32'd0);
        chk({tag, "_ctl"}, {26'd0, S, M, CN}, 32'd0);
    endtask

    initial begin
        logic [4:0] op;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk_all_zero("reset");

        run_op({1'b0, S_ADD}, 1'b0, 1'b0, 8'hFF, 8'h01, 0, 0, 1'b0);
        chk("lit_add_dout", 32'(DOUT), 32'h00);
        chk("lit_add_flags", {29'd0, CY, ZF, EQ}, 32'b110);

        run_op({1'b0, S_ADD}, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b0);
        chk("lit_chain_dout", 32'(DOUT), 32'h01);
        chk("lit_chain_flags", {30'd0, CY, ZF}, 32'b00);

        run_op({1'b0, S_SUB}, 1'b0, 1'b0, 8'h05, 8'h05, 0, 0, 1'b0);
        chk("lit_subeq_dout", 32'(DOUT), 32'h00);
        chk("lit_subeq_flags", {29'd0, CY, ZF, EQ}, 32'b011);

        run_op({1'b0, S_SUB}, 1'b0, 1'b0, 8'h03, 8'h05, 0, 0, 1'b0);
        chk("lit_subbr_dout", 32'(DOUT), 32'hFE);
        chk("lit_subbr_flags", {29'd0, CY, ZF, EQ}, 32'b100);

        run_op({1'b1, S_AND}, 1'b0, 1'b0, 8'hF0, 8'h3C, 0, 0, 1'b0);
        chk("lit_and_dout", 32'(DOUT), 32'h30);
        chk("lit_and_flags", {30'd0, CY, ZF}, 32'b10);

        run_op({1'b0, S_ADD}, 1'b0, 1'b1, 8'h12, 8'h34, 3, 2, 1'b1);
        chk("lit_stall_dout", 32'(DOUT), 32'h47);

        // Reset in the middle of LD_B with CY=1 and a chained op in flight.
        run_op({1'b0, S_ADD}, 1'b0, 1'b0, 8'hFF, 8'h01, 0, 0, 1'b0);
        START = 1'b1; OP = {1'b0, S_ADD}; USE_CY = 1'b1; CIN = 1'b0;
        @(negedge CLK);
        START = 1'b0; DIN_VLD = 1'b1; DIN = 8'hA5;
        @(negedge CLK);
        DIN_VLD = 1'b0;
        chk("pre_reset_cn", 32'(CN), 32'd1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_cy = 1'b0;
        chk_all_zero("midreset");
        repeat (6) @(negedge CLK);
        chk("post_reset_done", 32'(DONE), 32'd0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0, 1:    op = {1'b0, S_ADD};
                2:       op = {1'b0, S_SUB};
                3:       op = {1'b1, S_AND};
                default: op = {1'b1, (($urandom_range(0, 1) == 0) ? 4'b1110 : 4'b0110)};
            endcase
            run_op(op, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
